// File: rtl/tb_txn_scheduler_if.sv
// -----------------------------------------------------------------------------
// tb_txn_scheduler_if
//   Bundle of the per-diagram trigger/status lanes between the transaction
//   scheduler and the SynaptiCAD transaction diagrams it sequences.
//
//   Lane i occupies bits [2i+1:2i] of each vector.
//     tb_trigger : scheduler -> diagram   (TB_DONE/TB_ONCE/TB_LOOPING/TB_ABORT)
//     tb_status  : diagram  -> scheduler  (same encoding)
//
//   Modports
//     master : the scheduler (drives tb_trigger, observes tb_status)
//     slave  : the diagrams  (observe tb_trigger, drive tb_status)
// -----------------------------------------------------------------------------
interface tb_txn_scheduler_if #(
  parameter int NUM_DIAG = 4
);
  logic [2*NUM_DIAG-1:0] tb_trigger;
  logic [2*NUM_DIAG-1:0] tb_status;

  modport master (
    output tb_trigger,
    input  tb_status
  );

  modport slave (
    input  tb_trigger,
    output tb_status
  );
endinterface

// File: rtl/tb_txn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_txn_scheduler
//   Sequences TB_ONCE over a masked set of transaction diagrams in ascending
//   index order (mode 0), or holds one selected diagram in TB_LOOPING until
//   abort (mode 1). Counts completed transactions and flags protocol errors.
//
//   Ports
//     clk        : clock, all state on the rising edge
//     rst_n      : asynchronous active-low reset
//     start      : one-cycle run request, honoured only in IDLE without abort
//     mode       : 0 = sequential TB_ONCE over diag_mask, 1 = TB_LOOPING on sel
//     diag_mask  : diagrams enabled for mode 0 (sampled at start)
//     sel        : diagram for mode 1 (sampled at start)
//     abort      : level, terminates the active run
//     diag       : trigger/status lanes (tb_txn_scheduler_if, master side)
//     busy       : high in every state except IDLE
//     done       : one-cycle pulse while in FINISH
//     cur_idx    : index of the active diagram, held after the run
//     run_count  : completed transactions, saturating
//     err        : sticky protocol error, cleared on an accepted start
//
//   Optional build macro
//     TB_TXN_SCHED_TIMEOUT_EN : per-phase timeout of TIMEOUT cycles in ISSUE,
//                               WAIT_DONE and ABORTING. Without it the
//                               handshakes wait indefinitely.
// -----------------------------------------------------------------------------
module tb_txn_scheduler #(
  parameter int NUM_DIAG = 4,
  parameter int IDX_W    = 2,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic [NUM_DIAG-1:0]  diag_mask,
  input  logic [IDX_W-1:0]     sel,
  input  logic                 abort,
  tb_txn_scheduler_if.master   diag,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_W-1:0]     cur_idx,
  output logic [CNT_W-1:0]     run_count,
  output logic                 err
);

  localparam logic [1:0] TB_DONE    = 2'b00;
  localparam logic [1:0] TB_ONCE    = 2'b01;
  localparam logic [1:0] TB_LOOPING = 2'b10;
  localparam logic [1:0] TB_ABORT   = 2'b11;

  typedef enum logic [2:0] {
    IDLE, SCAN, ISSUE, WAIT_DONE, LOOP, ABORTING, FINISH
  } state_t;

  generate
    if (NUM_DIAG < 1 || NUM_DIAG > 8 || IDX_W < 1 || (1 << IDX_W) < NUM_DIAG ||
        CNT_W < 1 || TIMEOUT < 2) begin : g_param_check
      $error("tb_txn_scheduler: illegal parameter combination");
    end
  endgenerate

  state_t                state_reg;
  logic                  mode_reg;
  logic [NUM_DIAG-1:0]   mask_reg;
  logic                  issue_entry_reg;   // first cycle in ISSUE: check target is idle
  logic [2*NUM_DIAG-1:0] trigger_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic [IDX_W-1:0]      cur_idx_reg;
  logic [CNT_W-1:0]      run_count_reg;
  logic                  err_reg;

  logic [1:0]            status_arr [NUM_DIAG];
  logic [NUM_DIAG-1:0]   idx_onehot;
  logic [NUM_DIAG-1:0]   status_busy;
  logic [1:0]            tgt_status;
  logic                  other_busy;
  logic                  found;
  logic [IDX_W-1:0]      found_idx;
  logic                  last_idx;
  logic [1:0]            trig_val;
  logic [CNT_W-1:0]      run_count_inc;
  logic                  phase_timeout;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIAG; gi++) begin : g_lane
      assign status_arr[gi]  = diag.tb_status[2*gi +: 2];
      assign idx_onehot[gi]  = (cur_idx_reg == IDX_W'(gi));
      assign status_busy[gi] = (status_arr[gi] != TB_DONE);
    end
  endgenerate

  always_comb begin
    tgt_status = TB_DONE;
    for (int i = 0; i < NUM_DIAG; i++) begin
      if (idx_onehot[i]) tgt_status = status_arr[i];
    end
  end

  // Lowest enabled diagram at or above the current index. Walk downward so
  // the last hit is the lowest.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = NUM_DIAG - 1; i >= 0; i--) begin
      if (mask_reg[i] && (IDX_W'(i) >= cur_idx_reg)) begin
        found     = 1'b1;
        found_idx = IDX_W'(i);
      end
    end
  end

  assign other_busy    = |(status_busy & ~idx_onehot);
  assign last_idx      = (cur_idx_reg >= IDX_W'(NUM_DIAG - 1));
  assign trig_val      = mode_reg ? TB_LOOPING : TB_ONCE;
  assign run_count_inc = (run_count_reg == '1) ? run_count_reg : run_count_reg + CNT_W'(1);

  // Trigger vector with only the active lane carrying val.
  function automatic logic [2*NUM_DIAG-1:0] lane_drive(input logic [1:0] val,
                                                       input logic [NUM_DIAG-1:0] onehot);
    logic [2*NUM_DIAG-1:0] vec;
    vec = '0;
    for (int i = 0; i < NUM_DIAG; i++) begin
      if (onehot[i]) vec[2*i +: 2] = val;
    end
    return vec;
  endfunction

`ifdef TB_TXN_SCHED_TIMEOUT_EN
  localparam int PH_W = $clog2(TIMEOUT + 1);

  logic [PH_W-1:0] phase_cnt_reg;
  state_t          state_prev_reg;
  logic [PH_W-1:0] phase_elapsed;
  logic            timed_state;

  // Cycles already spent in the current state; restarts on any state change.
  assign timed_state   = (state_reg == ISSUE) || (state_reg == WAIT_DONE) ||
                         (state_reg == ABORTING);
  assign phase_elapsed = (state_reg != state_prev_reg) ? '0 : phase_cnt_reg;
  assign phase_timeout = timed_state && (phase_elapsed == PH_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt_reg  <= '0;
      state_prev_reg <= IDLE;
    end else begin
      state_prev_reg <= state_reg;
      phase_cnt_reg  <= timed_state ? phase_elapsed + PH_W'(1) : '0;
    end
  end
`else
  assign phase_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      mode_reg        <= 1'b0;
      mask_reg        <= '0;
      issue_entry_reg <= 1'b0;
      trigger_reg     <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      cur_idx_reg     <= '0;
      run_count_reg   <= '0;
      err_reg         <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg != IDLE && other_busy) err_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (start && !abort) begin
            mode_reg        <= mode;
            mask_reg        <= diag_mask;
            err_reg         <= 1'b0;
            busy_reg        <= 1'b1;
            issue_entry_reg <= 1'b1;
            if (mode) begin
              cur_idx_reg <= sel;
              state_reg   <= ISSUE;
            end else begin
              cur_idx_reg <= '0;
              state_reg   <= SCAN;
            end
          end
        end

        SCAN: begin
          if (found) begin
            cur_idx_reg     <= found_idx;
            issue_entry_reg <= 1'b1;
            state_reg       <= ISSUE;
          end else begin
            done_reg  <= 1'b1;
            state_reg <= FINISH;
          end
        end

        ISSUE: begin
          issue_entry_reg <= 1'b0;
          if (abort) begin
            trigger_reg <= lane_drive(TB_ABORT, idx_onehot);
            state_reg   <= ABORTING;
          end else if (phase_timeout) begin
            err_reg     <= 1'b1;
            trigger_reg <= lane_drive(TB_ABORT, idx_onehot);
            state_reg   <= ABORTING;
          end else if (issue_entry_reg) begin
            if (tgt_status != TB_DONE) begin
              // Diagram already executing: skip it without touching its trigger.
              err_reg <= 1'b1;
              if (mode_reg || last_idx) begin
                done_reg  <= 1'b1;
                state_reg <= FINISH;
              end else begin
                cur_idx_reg <= cur_idx_reg + IDX_W'(1);
                state_reg   <= SCAN;
              end
            end else begin
              trigger_reg <= lane_drive(trig_val, idx_onehot);
            end
          end else if (tgt_status == trig_val) begin
            if (mode_reg) begin
              state_reg <= LOOP;
            end else begin
              trigger_reg <= '0;
              state_reg   <= WAIT_DONE;
            end
          end
        end

        WAIT_DONE: begin
          if (abort || phase_timeout) begin
            if (!abort) err_reg <= 1'b1;
            trigger_reg <= lane_drive(TB_ABORT, idx_onehot);
            state_reg   <= ABORTING;
          end else if (tgt_status == TB_DONE) begin
            run_count_reg <= run_count_inc;
            mask_reg      <= mask_reg & ~idx_onehot;
            if (last_idx) begin
              done_reg  <= 1'b1;
              state_reg <= FINISH;
            end else begin
              cur_idx_reg <= cur_idx_reg + IDX_W'(1);
              state_reg   <= SCAN;
            end
          end
        end

        LOOP: begin
          if (abort) begin
            trigger_reg <= lane_drive(TB_ABORT, idx_onehot);
            state_reg   <= ABORTING;
          end
        end

        ABORTING: begin
          if (tgt_status == TB_DONE) begin
            if (mode_reg) run_count_reg <= run_count_inc;
            trigger_reg <= '0;
            done_reg    <= 1'b1;
            state_reg   <= FINISH;
          end else if (phase_timeout) begin
            err_reg     <= 1'b1;
            trigger_reg <= '0;
            done_reg    <= 1'b1;
            state_reg   <= FINISH;
          end
        end

        FINISH: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          trigger_reg <= '0;
          busy_reg    <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign diag.tb_trigger = trigger_reg;
  assign busy            = busy_reg;
  assign done            = done_reg;
  assign cur_idx         = cur_idx_reg;
  assign run_count       = run_count_reg;
  assign err             = err_reg;

endmodule

// File: tb/tb_tb_txn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tb_txn_scheduler
//   Bench for tb_txn_scheduler with four diagram models. Each model answers
//   its trigger after three clocks (TB_ABORT is answered with TB_DONE); a
//   per-lane override pins a status to model a stuck or already-running
//   diagram. Table-driven runs plus hand-written reset/timing sequences.
// -----------------------------------------------------------------------------
module tb_tb_txn_scheduler;

  localparam int ND = 4;
  localparam logic [1:0] TB_DONE    = 2'b00;
  localparam logic [1:0] TB_ONCE    = 2'b01;
  localparam logic [1:0] TB_LOOPING = 2'b10;
  localparam logic [1:0] TB_ABORT   = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic        abort;
  logic [3:0]  diag_mask;
  logic [1:0]  sel;
  logic        busy;
  logic        done;
  logic [1:0]  cur_idx;
  logic [15:0] run_count;
  logic        err;

  always #5 clk = ~clk;

  tb_txn_scheduler_if #(.NUM_DIAG(ND)) dif ();

  tb_txn_scheduler #(
    .NUM_DIAG (ND),
    .IDX_W    (2),
    .CNT_W    (16),
    .TIMEOUT  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .diag_mask (diag_mask),
    .sel       (sel),
    .abort     (abort),
    .diag      (dif),
    .busy      (busy),
    .done      (done),
    .cur_idx   (cur_idx),
    .run_count (run_count),
    .err       (err)
  );

  // Diagram models: status follows trigger three clocks later.
  logic [1:0] pipe [ND][3];
  bit         ovr_en  [ND];
  logic [1:0] ovr_val [ND];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < ND; i++) begin
      if (!rst_n) begin
        pipe[i][0] <= TB_DONE;
        pipe[i][1] <= TB_DONE;
        pipe[i][2] <= TB_DONE;
      end else begin
        pipe[i][0] <= (dif.tb_trigger[2*i +: 2] == TB_ABORT) ? TB_DONE : dif.tb_trigger[2*i +: 2];
        pipe[i][1] <= pipe[i][0];
        pipe[i][2] <= pipe[i][1];
      end
    end
  end

  always_comb begin
    dif.tb_status = '0;
    for (int i = 0; i < ND; i++) begin
      dif.tb_status[2*i +: 2] = ovr_en[i] ? ovr_val[i] : pipe[i][2];
    end
  end

  typedef struct {
    bit         mode;
    logic [3:0] mask;
    logic [1:0] sel;
    int         hold;       // mode 1: cycles before abort (0 = expect no loop)
    bit         ovr_en;
    int         ovr_idx;
    logic [1:0] ovr_val;
    logic [15:0] exp_order; // one nibble (index+1) per issued diagram
    int         exp_inc;
    bit         exp_err;
  } vec_t;

  vec_t vecs [11];

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          done_cnt;
  logic [15:0] order_code;
  bit          abort_seen;
  logic [1:0]  prev_trig [ND];
  int          exp_rc;

  function automatic logic [1:0] trig_of(input int i);
    return dif.tb_trigger[2*i +: 2];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and update the trigger/done monitors.
  task automatic tick();
    logic [1:0] cur;
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
    for (int i = 0; i < ND; i++) begin
      cur = trig_of(i);
      if (prev_trig[i] == TB_DONE && (cur == TB_ONCE || cur == TB_LOOPING))
        order_code = (order_code << 4) | 16'(i + 1);
      if (cur == TB_ABORT) abort_seen = 1'b1;
      prev_trig[i] = cur;
    end
  endtask

  task automatic clear_mon();
    done_cnt   = 0;
    order_code = '0;
    abort_seen = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    bit ok;
    clear_mon();
    if (v.ovr_en) begin
      ovr_en[v.ovr_idx]  = 1'b1;
      ovr_val[v.ovr_idx] = v.ovr_val;
    end
    mode = v.mode; diag_mask = v.mask; sel = v.sel; start = 1'b1;
    tick();
    start = 1'b0;
    if (v.mode && v.hold > 0) begin
      repeat (v.hold) tick();
      check($sformatf("v%0d_loop_hold", id), 32'(trig_of(int'(v.sel))), 32'(TB_LOOPING));
      check($sformatf("v%0d_busy_loop", id), 32'(busy), 32'd1);
      abort = 1'b1;
    end
    wait_done(300, ok);
    abort = 1'b0;
    check($sformatf("v%0d_done_seen", id), 32'(ok), 32'd1);
    tick();
    tick();
    exp_rc += v.exp_inc;
    check($sformatf("v%0d_order", id), 32'(order_code), 32'(v.exp_order));
    check($sformatf("v%0d_run_count", id), 32'(run_count), 32'(exp_rc));
    check($sformatf("v%0d_err", id), 32'(err), 32'(v.exp_err));
    check($sformatf("v%0d_done_pulses", id), 32'(done_cnt), 32'd1);
    check($sformatf("v%0d_trig_idle", id), 32'(dif.tb_trigger), 32'd0);
    check($sformatf("v%0d_busy_end", id), 32'(busy), 32'd0);
    $display("run %0d: mode=%0d mask=%b sel=%0d order=%h run_count=%0d err=%0d",
             id, v.mode, v.mask, v.sel, order_code, run_count, err);
    if (v.ovr_en) ovr_en[v.ovr_idx] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int abort_at;

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0; diag_mask = '0; sel = '0;
    for (int i = 0; i < ND; i++) begin
      ovr_en[i]    = 1'b0;
      ovr_val[i]   = TB_DONE;
      prev_trig[i] = TB_DONE;
    end
    clear_mon();
    exp_rc = 0;

    //             mode mask     sel hold ovr idx val         order    inc err
    vecs[0]  = '{1'b0, 4'b1010, 2'd0,  0, 1'b0, 0, TB_DONE,    16'h0024, 2, 1'b0};
    vecs[1]  = '{1'b0, 4'b1111, 2'd0,  0, 1'b0, 0, TB_DONE,    16'h1234, 4, 1'b0};
    vecs[2]  = '{1'b0, 4'b0001, 2'd0,  0, 1'b0, 0, TB_DONE,    16'h0001, 1, 1'b0};
    vecs[3]  = '{1'b0, 4'b1000, 2'd0,  0, 1'b0, 0, TB_DONE,    16'h0004, 1, 1'b0};
    vecs[4]  = '{1'b1, 4'b0000, 2'd2, 50, 1'b0, 0, TB_DONE,    16'h0003, 1, 1'b0};
    vecs[5]  = '{1'b1, 4'b1111, 2'd0,  5, 1'b0, 0, TB_DONE,    16'h0001, 1, 1'b0};
    vecs[6]  = '{1'b1, 4'b0000, 2'd3, 10, 1'b0, 0, TB_DONE,    16'h0004, 1, 1'b0};
    vecs[7]  = '{1'b0, 4'b0011, 2'd0,  0, 1'b1, 0, TB_ONCE,    16'h0002, 1, 1'b1};
    vecs[8]  = '{1'b0, 4'b0101, 2'd0,  0, 1'b0, 0, TB_DONE,    16'h0013, 2, 1'b0};
    vecs[9]  = '{1'b1, 4'b0000, 2'd1,  0, 1'b1, 1, TB_LOOPING, 16'h0000, 0, 1'b1};
    vecs[10] = '{1'b0, 4'b0000, 2'd0,  0, 1'b0, 0, TB_DONE,    16'h0000, 0, 1'b0};

    // Reset state.
    repeat (3) tick();
    check("rst_trigger", 32'(dif.tb_trigger), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cur_idx", 32'(cur_idx), 32'd0);
    check("rst_run_count", 32'(run_count), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Empty mask: done exactly two cycles after start.
    clear_mon();
    mode = 1'b0; diag_mask = 4'b0000; start = 1'b1;
    tick();
    start = 1'b0;
    check("empty_t1_done", 32'(done), 32'd0);
    check("empty_t1_busy", 32'(busy), 32'd1);
    tick();
    check("empty_t2_done", 32'(done), 32'd1);
    tick();
    check("empty_t3_done", 32'(done), 32'd0);
    check("empty_t3_busy", 32'(busy), 32'd0);
    check("empty_trig", 32'(dif.tb_trigger), 32'd0);
    check("empty_run_count", 32'(run_count), 32'(exp_rc));
    $display("empty-mask run: done pulses=%0d run_count=%0d", done_cnt, run_count);

    // start together with abort is ignored.
    mode = 1'b0; diag_mask = 4'b0001; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    check("start_with_abort_busy", 32'(busy), 32'd0);
    $display("start+abort: busy=%0d", busy);

    for (int v = 0; v < 11; v++) run_vec(v, vecs[v]);

    // Reset during WAIT_DONE.
    clear_mon();
    mode = 1'b0; diag_mask = 4'b0001; start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (order_code != 0) begin ok = 1'b1; break; end
      tick();
    end
    check("rstmid_issue_seen", 32'(ok), 32'd1);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (trig_of(0) == TB_DONE) begin ok = 1'b1; break; end
      tick();
    end
    check("rstmid_wait_done_reached", 32'(ok), 32'd1);
    check("rstmid_busy_before", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_trigger", 32'(dif.tb_trigger), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_cur_idx", 32'(cur_idx), 32'd0);
    check("rstmid_run_count", 32'(run_count), 32'd0);
    check("rstmid_err", 32'(err), 32'd0);
    $display("reset mid-run: busy=%0d run_count=%0d", busy, run_count);
    exp_rc = 0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    run_vec(20, '{1'b0, 4'b0100, 2'd0, 0, 1'b0, 0, TB_DONE, 16'h0003, 1, 1'b0});

    // Diagram 1 never acknowledges.
    clear_mon();
    ovr_en[1] = 1'b1; ovr_val[1] = TB_DONE;
    mode = 1'b0; diag_mask = 4'b0010; start = 1'b1;
    tick();
    start = 1'b0;
`ifdef TB_TXN_SCHED_TIMEOUT_EN
    abort_at = -1;
    for (int k = 1; k <= 60; k++) begin
      if (abort_at < 0 && trig_of(1) == TB_ABORT) abort_at = k;
      if (done_cnt > 0) break;
      tick();
    end
    check("tmo_abort_cycle", 32'(abort_at), 32'd18);
    check("tmo_done", 32'(done_cnt), 32'd1);
    tick();
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_run_count", 32'(run_count), 32'(exp_rc));
`else
    abort_at = 0;
    repeat (60) tick();
    check("noack_busy", 32'(busy), 32'd1);
    check("noack_trig", 32'(trig_of(1)), 32'(TB_ONCE));
    check("noack_no_done", 32'(done_cnt), 32'd0);
    abort = 1'b1;
    wait_done(50, ok);
    abort = 1'b0;
    check("noack_abort_done", 32'(ok), 32'd1);
    check("noack_abort_seen", 32'(abort_seen), 32'd1);
    tick();
    check("noack_err", 32'(err), 32'd0);
    check("noack_run_count", 32'(run_count), 32'(exp_rc));
`endif
    tick();
    check("noack_trig_idle", 32'(dif.tb_trigger), 32'd0);
    check("noack_busy_end", 32'(busy), 32'd0);
    $display("no-ack run: abort_at=%0d err=%0d run_count=%0d", abort_at, err, run_count);
    ovr_en[1] = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
